// File: rtl/fl_frame_arbiter.sv
// Round-robin FrameLink frame arbiter: grants whole frames from INPUTS requesters
// onto one output stream, admitting a new frame only when the FIFO has room.
module fl_frame_arbiter #(
  parameter int INPUTS       = 4,
  parameter int DATA_WIDTH   = 128,
  parameter int DREM_WIDTH   = $clog2(DATA_WIDTH / 8),
  parameter int STATUS_WIDTH = 7,
  parameter int MIN_FREE     = 4
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic [INPUTS*DATA_WIDTH-1:0] RX_DATA,
  input  logic [INPUTS*DREM_WIDTH-1:0] RX_REM,
  input  logic [INPUTS-1:0]            RX_SOF_N,
  input  logic [INPUTS-1:0]            RX_EOF_N,
  input  logic [INPUTS-1:0]            RX_SOP_N,
  input  logic [INPUTS-1:0]            RX_EOP_N,
  input  logic [INPUTS-1:0]            RX_SRC_RDY_N,
  output logic [INPUTS-1:0]            RX_DST_RDY_N,
  output logic [DATA_WIDTH-1:0]        TX_DATA,
  output logic [DREM_WIDTH-1:0]        TX_REM,
  output logic                         TX_SOF_N,
  output logic                         TX_EOF_N,
  output logic                         TX_SOP_N,
  output logic                         TX_EOP_N,
  output logic                         TX_SRC_RDY_N,
  input  logic                         TX_DST_RDY_N,
  input  logic [STATUS_WIDTH-1:0]      FIFO_STATUS,
  output logic [INPUTS-1:0]            GRANT
);

  localparam int PTR_W = (INPUTS > 1) ? $clog2(INPUTS) : 1;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [PTR_W-1:0]    r_ptr, w_ptr_nxt;
  logic [PTR_W-1:0]    r_gidx, w_gidx_nxt;
  logic [INPUTS-1:0]   r_grant, w_grant_nxt;
  logic [INPUTS-1:0]   w_elig;
  logic [PTR_W-1:0]    w_pick;
  logic                w_found;
  logic                w_space_ok;
  logic                w_xfer;
  logic                w_last;

  assign w_space_ok = (FIFO_STATUS >= STATUS_WIDTH'(MIN_FREE));
  assign w_elig     = ~RX_SRC_RDY_N & ~RX_SOF_N & {INPUTS{w_space_ok}};
  assign w_xfer     = (r_state == ST_LOCKED) & ~TX_SRC_RDY_N & ~TX_DST_RDY_N;
  assign w_last     = ~TX_EOF_N;
  assign GRANT      = r_grant;

  // Round-robin search: first eligible requester starting at r_ptr.
  always_comb begin
    int idx;
    w_found = 1'b0;
    w_pick  = {PTR_W{1'b0}};
    idx     = 0;
    for (int k = 0; k < INPUTS; k++) begin
      idx = (int'(r_ptr) + k) % INPUTS;
      if (!w_found && w_elig[PTR_W'(idx)]) begin
        w_found = 1'b1;
        w_pick  = PTR_W'(idx);
      end else begin
        w_found = w_found;
      end
    end
  end

  // Next-state logic: lock on a winner, release after the EOF word transfers.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_gidx_nxt  = r_gidx;
    w_grant_nxt = r_grant;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_nxt = ST_LOCKED;
          w_gidx_nxt  = w_pick;
          w_grant_nxt = {{(INPUTS-1){1'b0}}, 1'b1} << w_pick;
        end else begin
          w_grant_nxt = {INPUTS{1'b0}};
        end
      end
      ST_LOCKED: begin
        if (w_xfer && w_last) begin
          w_state_nxt = ST_IDLE;
          w_grant_nxt = {INPUTS{1'b0}};
          w_ptr_nxt   = (r_gidx == PTR_W'(INPUTS - 1)) ? {PTR_W{1'b0}} : r_gidx + PTR_W'(1);
        end else begin
          w_state_nxt = ST_LOCKED;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = {INPUTS{1'b0}};
      end
    endcase
  end

  // State, pointer and grant registers.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state <= ST_IDLE;
      r_ptr   <= {PTR_W{1'b0}};
      r_gidx  <= {PTR_W{1'b0}};
      r_grant <= {INPUTS{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_gidx  <= w_gidx_nxt;
      r_grant <= w_grant_nxt;
    end
  end

  // Output steering: the owner is passed straight through so frames carry no added latency.
  always_comb begin
    TX_DATA      = {DATA_WIDTH{1'b0}};
    TX_REM       = {DREM_WIDTH{1'b0}};
    TX_SOF_N     = 1'b1;
    TX_EOF_N     = 1'b1;
    TX_SOP_N     = 1'b1;
    TX_EOP_N     = 1'b1;
    TX_SRC_RDY_N = 1'b1;
    RX_DST_RDY_N = {INPUTS{1'b1}};
    for (int i = 0; i < INPUTS; i++) begin
      if ((r_state == ST_LOCKED) && (r_gidx == PTR_W'(i))) begin
        TX_DATA         = RX_DATA[i*DATA_WIDTH +: DATA_WIDTH];
        TX_REM          = RX_REM[i*DREM_WIDTH +: DREM_WIDTH];
        TX_SOF_N        = RX_SOF_N[i];
        TX_EOF_N        = RX_EOF_N[i];
        TX_SOP_N        = RX_SOP_N[i];
        TX_EOP_N        = RX_EOP_N[i];
        TX_SRC_RDY_N    = RX_SRC_RDY_N[i];
        RX_DST_RDY_N[i] = TX_DST_RDY_N;
      end else begin
        RX_DST_RDY_N[i] = 1'b1;
      end
    end
  end

endmodule
